// File: rtl/adc_avg_pkg.sv
// Shared constants and helpers for the ADC channel averager.
package adc_avg_pkg;

  // Channel index width used on every channel-select and channel-tag port.
  localparam int CH_W = 3;

  // Default build parameters.
  localparam int DEF_NCHAN    = 2;
  localparam int DEF_LOG2_AVG = 2;
  localparam int DEF_DW       = 12;

  // Accumulator width: wide enough to hold 2^log2_avg full-scale samples.
  function automatic int acc_width(input int dw, input int log2_avg);
    return dw + log2_avg;
  endfunction

endpackage

// File: rtl/adc_avg_lane.sv
// One channel's boxcar accumulator: sums samples and flags the sample
// that completes a 2^LOG2_AVG average, presenting the truncated mean.
module adc_avg_lane
  import adc_avg_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int LOG2_AVG = DEF_LOG2_AVG
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sample_valid_i,
  input  logic [DW-1:0] sample_i,
  output logic          done_o,
  output logic [DW-1:0] result_o
);

  localparam int AW = acc_width(DW, LOG2_AVG);
  localparam int CW = LOG2_AVG + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(1'b1) << LOG2_AVG;

  logic [AW-1:0] acc_q, acc_d, sum_s;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic          done_s;

  // Running sum including the incoming sample; the completing sample is
  // folded in here so the result needs no extra cycle.
  always_comb begin
    sum_s     = acc_q + AW'(sample_i);
    cnt_inc_s = cnt_q + CW'(1'b1);
    done_s    = sample_valid_i && (cnt_inc_s == CNT_FULL);
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    if (sample_valid_i) begin
      if (done_s) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum_s;
        cnt_d = cnt_inc_s;
      end
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end

  // Accumulator and sample-count state.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign done_o   = done_s;
  // Dropping the low LOG2_AVG bits is the truncating divide.
  assign result_o = sum_s[AW-1:LOG2_AVG];

endmodule

// File: rtl/adc_channel_averager.sv
// Round-robin ADC channel sequencer with per-channel boxcar averaging and
// a single-entry valid/ready result register with sticky overrun.
module adc_channel_averager
  import adc_avg_pkg::*;
#(
  parameter int NCHAN    = DEF_NCHAN,
  parameter int LOG2_AVG = DEF_LOG2_AVG,
  parameter int DW       = DEF_DW
) (
  input  logic            clk,
  input  logic            reset,
  output logic [CH_W-1:0] adc_channel,
  input  logic [DW-1:0]   adc_data,
  input  logic            adc_ready,
  output logic [DW-1:0]   out_data,
  output logic [CH_W-1:0] out_channel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            overrun
);

  logic [CH_W-1:0] sel_q, sel_d, prev_q, prev_d;
  logic            prime_q, prime_d;

  logic [NCHAN-1:0] lane_done_s;
  logic [DW-1:0]    lane_result_s [NCHAN];
  logic             new_valid_s;
  logic [DW-1:0]    new_data_s;

  logic [DW-1:0]   out_data_q, out_data_d;
  logic [CH_W-1:0] out_channel_q, out_channel_d;
  logic            out_valid_q, out_valid_d;
  logic            overrun_q, overrun_d;

  // Advance the requested channel each frame; the converter answers one
  // frame late, so the returned sample belongs to the previous request.
  always_comb begin
    sel_d   = sel_q;
    prev_d  = prev_q;
    prime_d = prime_q;
    if (adc_ready) begin
      prev_d  = sel_q;
      sel_d   = (sel_q == CH_W'(NCHAN - 1)) ? '0 : sel_q + CH_W'(1'b1);
      prime_d = 1'b0;
    end else begin
      sel_d   = sel_q;
      prev_d  = prev_q;
      prime_d = prime_q;
    end
  end

  // Sequencer state; prime marks the first frame whose channel is unknown.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q   <= '0;
      prev_q  <= '0;
      prime_q <= 1'b1;
    end else begin
      sel_q   <= sel_d;
      prev_q  <= prev_d;
      prime_q <= prime_d;
    end
  end

  for (genvar c = 0; c < NCHAN; c++) begin : g_lane
    logic lane_valid_s;
    assign lane_valid_s = adc_ready && !prime_q && (prev_q == CH_W'(c));

    adc_avg_lane #(
      .DW       (DW),
      .LOG2_AVG (LOG2_AVG)
    ) u_lane (
      .clk            (clk),
      .reset          (reset),
      .sample_valid_i (lane_valid_s),
      .sample_i       (adc_data),
      .done_o         (lane_done_s[c]),
      .result_o       (lane_result_s[c])
    );
  end

  // At most one lane completes per frame, so an AND-OR mux picks its result.
  always_comb begin
    new_data_s  = '0;
    new_valid_s = |lane_done_s;
    for (int c = 0; c < NCHAN; c++) begin
      new_data_s = new_data_s | (lane_result_s[c] & {DW{lane_done_s[c]}});
    end
  end

  // Output register: load when free or being drained, otherwise drop the
  // new result and flag overrun while keeping the held one intact.
  always_comb begin
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    out_valid_d   = out_valid_q;
    overrun_d     = overrun_q;
    if (new_valid_s) begin
      if (!out_valid_q || out_ready) begin
        out_data_d    = new_data_s;
        out_channel_d = prev_q;
        out_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Result register state.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q    <= '0;
      out_channel_q <= '0;
      out_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      out_valid_q   <= out_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign adc_channel = sel_q;
  assign out_data    = out_data_q;
  assign out_channel = out_channel_q;
  assign out_valid   = out_valid_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_adc_channel_averager.sv
// Directed bench for adc_channel_averager: a frame table for the default
// two-channel build plus a one-channel, 64-sample build for full-scale sums.
module tb_adc_channel_averager;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic [2:0]  adc_channel;
  logic [11:0] adc_data = 12'h000;
  logic        adc_ready = 1'b0;
  logic [11:0] out_data;
  logic [2:0]  out_channel;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        overrun;

  logic [2:0]  b_adc_channel;
  logic [11:0] b_adc_data = 12'hFFF;
  logic        b_adc_ready = 1'b0;
  logic [11:0] b_out_data;
  logic [2:0]  b_out_channel;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic        b_overrun;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          rst;   // 0 none, 1 reset before frame, 2 reset with adc_ready
    logic [11:0] data;
    logic        ordy;
    logic [2:0]  ach;
    logic        v;
    logic [11:0] d;
    logic [2:0]  c;
    logic        o;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  adc_channel_averager #(.NCHAN(2), .LOG2_AVG(2), .DW(12)) dut (
    .clk         (clk),
    .reset       (reset),
    .adc_channel (adc_channel),
    .adc_data    (adc_data),
    .adc_ready   (adc_ready),
    .out_data    (out_data),
    .out_channel (out_channel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun)
  );

  adc_channel_averager #(.NCHAN(1), .LOG2_AVG(6), .DW(12)) dut_b (
    .clk         (clk),
    .reset       (reset),
    .adc_channel (b_adc_channel),
    .adc_data    (b_adc_data),
    .adc_ready   (b_adc_ready),
    .out_data    (b_out_data),
    .out_channel (b_out_channel),
    .out_valid   (b_out_valid),
    .out_ready   (b_out_ready),
    .overrun     (b_overrun)
  );

  function automatic logic [19:0] pk(input logic [2:0] ach, input logic v,
                                     input logic [11:0] d, input logic [2:0] c,
                                     input logic o);
    return {ach, v, d, c, o};
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {ach,v,data,ch,ovr}=%h required %h", name, act, exp);
    end
  endtask

  function automatic void add(input int rst, input logic [11:0] data, input logic ordy,
                              input logic [2:0] ach, input logic v, input logic [11:0] d,
                              input logic [2:0] c, input logic o);
    vec_t t;
    t.rst = rst; t.data = data; t.ordy = ordy; t.ach = ach;
    t.v = v; t.d = d; t.c = c; t.o = o;
    vq.push_back(t);
  endfunction

  task automatic do_reset(input logic with_ready);
    @(negedge clk);
    reset = 1'b1; adc_ready = with_ready; adc_data = 12'hFFF; out_ready = 1'b0;
    b_adc_ready = 1'b0;
    @(negedge clk);
    adc_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("reset", pk(adc_channel, out_valid, out_data, out_channel, overrun),
          pk(3'd0, 1'b0, 12'h000, 3'd0, 1'b0));
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    if (v.rst != 0) do_reset(v.rst == 2);
    @(negedge clk);
    adc_data = v.data; adc_ready = 1'b1; out_ready = v.ordy;
    @(negedge clk);
    adc_ready = 1'b0;
    check($sformatf("vec%0d", idx), pk(adc_channel, out_valid, out_data, out_channel, overrun),
          pk(v.ach, v.v, v.d, v.c, v.o));
    @(negedge clk);
  endtask

  task automatic pulse_b();
    @(negedge clk);
    b_adc_ready = 1'b1;
    @(negedge clk);
    b_adc_ready = 1'b0;
  endtask

  initial begin
    // A: model data 0x100*requested_ch + k, consumer always ready.
    add(1, 12'hABC, 1'b1, 3'd1, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h001, 1'b1, 3'd0, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h102, 1'b1, 3'd1, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h003, 1'b1, 3'd0, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h104, 1'b1, 3'd1, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h005, 1'b1, 3'd0, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h106, 1'b1, 3'd1, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h007, 1'b1, 3'd0, 1'b1, 12'h004, 3'd0, 1'b0);
    add(0, 12'h108, 1'b1, 3'd1, 1'b1, 12'h105, 3'd1, 1'b0);
    // B: ch0 = 1,1,1,2 -> 1; consumer stalled, ch1 result dropped -> overrun.
    add(1, 12'h000, 1'b0, 3'd1, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h001, 1'b0, 3'd0, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h010, 1'b0, 3'd1, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h001, 1'b0, 3'd0, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h020, 1'b0, 3'd1, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h001, 1'b0, 3'd0, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h030, 1'b0, 3'd1, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h002, 1'b0, 3'd0, 1'b1, 12'h001, 3'd0, 1'b0);
    add(0, 12'h041, 1'b0, 3'd1, 1'b1, 12'h001, 3'd0, 1'b1);
    // C: new result completes in the same cycle the held one is accepted.
    add(1, 12'h555, 1'b0, 3'd1, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h010, 1'b0, 3'd0, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'hFFF, 1'b0, 3'd1, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h011, 1'b0, 3'd0, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'hFFF, 1'b0, 3'd1, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h012, 1'b0, 3'd0, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'hFFF, 1'b0, 3'd1, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h013, 1'b0, 3'd0, 1'b1, 12'h011, 3'd0, 1'b0);
    add(0, 12'hFFF, 1'b1, 3'd1, 1'b1, 12'hFFF, 3'd1, 1'b0);
    // R: reset (with a coincident adc_ready) after 3 of 4 ch0 samples.
    add(1, 12'h0AA, 1'b1, 3'd1, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h100, 1'b1, 3'd0, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h000, 1'b1, 3'd1, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h100, 1'b1, 3'd0, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h000, 1'b1, 3'd1, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h100, 1'b1, 3'd0, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h000, 1'b1, 3'd1, 1'b0, 12'h000, 3'd0, 1'b0);
    add(2, 12'h7FF, 1'b1, 3'd1, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h004, 1'b1, 3'd0, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h000, 1'b1, 3'd1, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h004, 1'b1, 3'd0, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h000, 1'b1, 3'd1, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h004, 1'b1, 3'd0, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h000, 1'b1, 3'd1, 1'b0, 12'h000, 3'd0, 1'b0);
    add(0, 12'h008, 1'b1, 3'd0, 1'b1, 12'h005, 3'd0, 1'b0);

    for (int i = 0; i < 18; i++) run_vec(vq[i], i);

    // Held result survives another stalled cycle, then one accept clears
    // out_valid while overrun stays sticky.
    check("hold", pk(adc_channel, out_valid, out_data, out_channel, overrun),
          pk(3'd1, 1'b1, 12'h001, 3'd0, 1'b1));
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("accept", pk(adc_channel, out_valid, out_data, out_channel, overrun),
          pk(3'd1, 1'b0, 12'h001, 3'd0, 1'b1));

    for (int i = 18; i < vq.size(); i++) run_vec(vq[i], i);

    // One channel, 64-sample average of full-scale input: no wrap.
    do_reset(1'b0);
    b_adc_data = 12'hFFF;
    b_out_ready = 1'b1;
    for (int i = 0; i < 64; i++) pulse_b();
    check("b_63_samples", pk(b_adc_channel, b_out_valid, b_out_data, b_out_channel, b_overrun),
          pk(3'd0, 1'b0, 12'h000, 3'd0, 1'b0));
    pulse_b();
    check("b_full_scale", pk(b_adc_channel, b_out_valid, b_out_data, b_out_channel, b_overrun),
          pk(3'd0, 1'b1, 12'hFFF, 3'd0, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_channel_averager.md
# adc_channel_averager

Round-robin channel sequencer and boxcar averager that sits directly downstream of the two-channel SPI ADC driver. It steers the driver's channel select each frame and attributes each returned sample to the channel requested one frame earlier, accounting for the converter's one-frame pipeline. It accumulates 2^LOG2_AVG samples per channel and presents the truncated mean on a valid/ready output port to the rest of the design.

## Interface
- NCHAN, 2: number of channels sequenced, 1..8; channels 0..NCHAN-1.
- LOG2_AVG, 2: log2 of samples averaged per result, 0..6.
- DW, 12: sample and result width.
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- adc_channel  out  3  channel select driven to the ADC driver.
- adc_data  in  DW  sample from the ADC driver; valid when adc_ready=1.
- adc_ready  in  1  one-cycle pulse per completed ADC frame.
- out_data  out  DW  averaged result.
- out_channel  out  3  channel of out_data.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result when out_valid&out_ready.
- overrun  out  1  sticky: a result was dropped because the output was still occupied.

## Operation
- State: `sel` (channel being requested), `prev` (channel requested in the previous frame), `prime` flag, per-channel accumulator `acc[c]` (DW+LOG2_AVG bits) and sample count `cnt[c]` (LOG2_AVG+1 bits).
- adc_channel = sel, registered.
- On each adc_ready:
  - prev <= sel; sel <= (sel==NCHAN-1) ? 0 : sel+1.
  - If prime=1: discard adc_data (channel unknown after reset) and clear prime.
  - Otherwise attribute the sample to channel `prev`:
    - acc[prev] += adc_data; cnt[prev] += 1.
    - When the count reaches 2^LOG2_AVG: the result is (acc + adc_data) >> LOG2_AVG, truncated with no rounding. Clear acc[prev] and cnt[prev] to 0.
- Output register:
  - If out_valid=0, or out_ready=1 in the same cycle: load out_data and out_channel, set out_valid=1.
  - Else: drop the new result, set overrun=1, and keep the held result unchanged.
- An accept with no new result clears out_valid.
- With NCHAN=1, sel and prev are constant 0.
- LOG2_AVG=0: every attributed sample is a result, passed through unshifted.
- Accumulator cannot overflow: width is DW+LOG2_AVG.

## Timing
- Reset values: adc_channel=0, out_valid=0, out_data=0, out_channel=0, overrun=0. All acc and cnt are 0, prime=1, prev=0.
- adc_channel changes the cycle after adc_ready, which is well before the driver samples it in the next frame.
- Latency: out_valid rises the cycle after the adc_ready that completes a channel's average.
- out_data and out_channel are stable while out_valid=1 and out_ready=0.
- Simultaneous new result and accept: the new result is loaded, out_valid stays 1, and overrun is not set.
- adc_ready together with reset: reset wins and the sample is discarded.
- Reset mid-average clears all partial sums. The first sample after reset is always discarded.
- adc_ready pulses are at least 2 cycles apart; closer pulses are not supported.

## Structure
- Package adc_avg_pkg: channel-index width constant (3), default NCHAN/LOG2_AVG/DW, and the accumulator-width function DW+LOG2_AVG.
- One natural sub-module, adc_avg_lane: a single channel's accumulator, counter and done detection, instantiated NCHAN times and indexed by prev.
- The sequencer and output register live in the top level.

## Test plan
- Reset, NCHAN=2, LOG2_AVG=2; the ADC model returns 0x100*requested_ch + k per frame. Required response:
  - adc_channel toggles 0,1,0,1.
  - First sample is discarded.
  - Results arrive as ch0 then ch1, each equal to the model's mean >> 2.
- Constant 0xFFF on all frames, LOG2_AVG=6 -> results exactly 0xFFF with no overflow wrap.
- Samples 1,1,1,2 on ch0 -> out_data=1 (truncation, no rounding).
- Hold out_ready=0 across two completed results -> first result held unchanged, overrun=1 one cycle after the second completion, no second out_valid edge.
- out_ready=1 in the cycle a new result completes while out_valid=1 -> new result loaded, overrun stays 0.
- Assert reset after 3 of 4 ch0 samples, then resume -> outputs at reset values, and the next ch0 result uses only post-reset samples after one discarded frame.
